// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and its downstream byte buffer.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: captures receiver strobes into a circular array and
// presents them first-word-fall-through with occupancy and overflow reporting.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W       = UART_DATA_W,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       wr_valid_i,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       afull_o,
  output logic                       overflow_o,
  input  logic                       ovf_clr_i
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_count;
  logic              r_overflow;

  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;

  assign w_wr_idx = r_wr_ptr[IDX_W-1:0];
  assign w_rd_idx = r_rd_ptr[IDX_W-1:0];
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (w_wr_idx == w_rd_idx) && (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]);

  // A pop in the same cycle frees the head slot, so a full buffer can still accept.
  assign w_pop  = !w_empty && rd_ready_i;
  assign w_push = wr_valid_i && (!w_full || w_pop);
  assign w_drop = wr_valid_i && w_full && !w_pop;

  // NOTE: the array is inside the async reset so rd_data_o reads 0 during and
  // after reset; this costs a reset net per storage flop instead of a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[w_wr_idx] <= wr_data_i;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + PTR_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - PTR_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr_i) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign rd_data_o  = r_mem[w_rd_idx];
  assign rd_valid_o = !w_empty;
  assign count_o    = r_count;
  assign afull_o    = (r_count >= PTR_W'(AFULL_THRESH));
  assign overflow_o = r_overflow;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo: vector table plus hand-written
// sequences for fill/drain, overflow, full push+pop, wrap and mid-stream reset.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int THR   = 12;

  logic       clk;
  logic       rst_n;
  uart_byte_t wr_data_i;
  logic       wr_valid_i;
  uart_byte_t rd_data_o;
  logic       rd_valid_o;
  logic       rd_ready_i;
  logic [4:0] count_o;
  logic       afull_o;
  logic       overflow_o;
  logic       ovf_clr_i;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_fifo #(.DATA_W(UART_DATA_W), .DEPTH(DEPTH), .AFULL_THRESH(THR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_data_i  (wr_data_i),
    .wr_valid_i (wr_valid_i),
    .rd_data_o  (rd_data_o),
    .rd_valid_o (rd_valid_o),
    .rd_ready_i (rd_ready_i),
    .count_o    (count_o),
    .afull_o    (afull_o),
    .overflow_o (overflow_o),
    .ovf_clr_i  (ovf_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wv;
    uart_byte_t wd;
    logic       rr;
    logic       oc;
    logic       ev;
    uart_byte_t ed;
    int         ec;
    logic       ea;
    logic       eo;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it, then sample 1 time unit after the edge.
  task automatic step(input logic wv, input uart_byte_t wd, input logic rr, input logic oc);
    wr_valid_i = wv;
    wr_data_i  = wd;
    rd_ready_i = rr;
    ovf_clr_i  = oc;
    @(posedge clk);
    #1;
    wr_valid_i = 1'b0;
    rd_ready_i = 1'b0;
    ovf_clr_i  = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic ev, input int ec,
                             input logic ea, input logic eo);
    check({tag, "_valid"}, int'(rd_valid_o), int'(ev));
    check({tag, "_count"}, int'(count_o), ec);
    check({tag, "_afull"}, int'(afull_o), int'(ea));
    check({tag, "_ovf"}, int'(overflow_o), int'(eo));
  endtask

  initial begin
    rst_n      = 1'b0;
    wr_valid_i = 1'b0;
    wr_data_i  = '0;
    rd_ready_i = 1'b0;
    ovf_clr_i  = 1'b0;

    // Empty-buffer vectors: latency, pop, no bypass, pop-on-empty ignored.
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h7E, 1'b1, 1'b0, 1'b1, 8'h7E, 1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0};

    #12;
    check_state("reset", 1'b0, 0, 1'b0, 1'b0);
    check("reset_data", int'(rd_data_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      step(vecs[i].wv, vecs[i].wd, vecs[i].rr, vecs[i].oc);
      check_state($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ec, vecs[i].ea, vecs[i].eo);
      if (vecs[i].ev) check($sformatf("vec%0d_data", i), int'(rd_data_o), int'(vecs[i].ed));
    end

    // Fill 0x00..0x0F: afull rises after the 12th push, no overflow at 16.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, uart_byte_t'(i), 1'b0, 1'b0);
      check_state($sformatf("fill%0d", i), 1'b1, i + 1, (i + 1) >= THR, 1'b0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain%0d_data", i), int'(rd_data_o), i);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check($sformatf("drain%0d_count", i), int'(count_o), DEPTH - 1 - i);
    end
    check("drain_empty", int'(rd_valid_o), 0);

    // Overflow: drop while full, clear, then drop+clear in one cycle (set wins).
    for (int i = 0; i < DEPTH; i++) step(1'b1, uart_byte_t'(8'h10 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    check_state("drop", 1'b1, DEPTH, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_clr", int'(overflow_o), 0);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    check("drop_and_clr", int'(overflow_o), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_clr2", int'(overflow_o), 0);

    // Full with simultaneous push+pop: both proceed, 0x55 comes out last.
    check("fullpp_head", int'(rd_data_o), 'h10);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    check_state("fullpp", 1'b1, DEPTH, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("fullpp_drain%0d", i), int'(rd_data_o), (i < DEPTH - 1) ? 'h11 + i : 'h55);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check_state("fullpp_end", 1'b0, 0, 1'b0, 1'b0);

    // Streaming 0..39 with ready high: each byte visible one cycle after its push.
    for (int i = 0; i < 40; i++) begin
      step(1'b1, uart_byte_t'(i), 1'b1, 1'b0);
      check($sformatf("stream%0d_data", i), int'(rd_data_o), i);
      check($sformatf("stream%0d_valid", i), int'(rd_valid_o), 1);
      check($sformatf("stream%0d_cnt_le1", i), int'(count_o <= 5'd1), 1);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_state("stream_end", 1'b0, 0, 1'b0, 1'b0);

    // Mid-stream reset discards contents asynchronously.
    for (int i = 0; i < 5; i++) step(1'b1, uart_byte_t'(8'hC0 + i), 1'b0, 1'b0);
    check("pre_rst_count", int'(count_o), 5);
    #2;
    rst_n = 1'b0;
    #1;
    check_state("midrst", 1'b0, 0, 1'b0, 1'b0);
    check("midrst_data", int'(rd_data_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 8'h9B, 1'b0, 1'b0);
    check_state("post_rst", 1'b1, 1, 1'b0, 1'b0);
    check("post_rst_data", int'(rd_data_o), 'h9B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_rx_fifo
